// File: rtl/life_pkg.sv
// ============================================================================
// life_pkg : shared types, rule constants and elaboration helpers for life_grid
// Rev 1.0
// ============================================================================
`default_nettype none

package life_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } life_state_t;

  localparam logic [8:0] RULE_B3  = 9'b000001000;
  localparam logic [8:0] RULE_S23 = 9'b000001100;
  localparam logic [8:0] RULE_B36 = 9'b001001000;

  function automatic int CELL_NUM(input int w, input int h);
    return w * h;
  endfunction

  // Flat index of neighbour k (0..7, row-major around the cell, centre skipped),
  // or -1 when the neighbour lies outside a dead-border grid.
  function automatic int nbr_index(input int r, input int c, input int k,
                                   input int w, input int h, input int torus);
    int pos;
    int rr;
    int cc;
    pos = (k < 4) ? k : k + 1;
    rr  = r + pos / 3 - 1;
    cc  = c + pos % 3 - 1;
    if (torus != 0) begin
      rr = (rr + h) % h;
      cc = (cc + w) % w;
    end else if (rr < 0 || rr >= h || cc < 0 || cc >= w) begin
      return -1;
    end
    return rr * w + cc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/life_rule.sv
// ============================================================================
// life_rule : next state of one cell from its 8 neighbours and the rule masks
// Rev 1.0
// ============================================================================
`default_nettype none

module life_rule
  import life_pkg::*;
(
  input  logic [7:0] nbrs,
  input  logic       alive,
  input  logic [8:0] birth_mask,
  input  logic [8:0] survive_mask,
  output logic       next
);

  logic [3:0] count;

  always_comb begin
    count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      count = count + {3'b000, nbrs[i]};
    end
    next = alive ? survive_mask[count] : birth_mask[count];
  end

endmodule

`default_nettype wire

// File: rtl/life_grid.sv
// ============================================================================
// life_grid : Life-like cellular automaton with serial load and step handshake
// Optional macro LIFE_HISTORY_EN adds a previous-generation copy and osc2.
// Rev 1.0
// ============================================================================
`default_nettype none

module life_grid
  import life_pkg::*;
#(
  parameter int WIDTH  = 17,
  parameter int HEIGHT = 17,
  parameter int TORUS  = 1,
  parameter int GEN_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic                      load_valid,
  input  logic                      load_bit,
  output logic                      load_ready,
  input  logic [8:0]                birth_mask,
  input  logic [8:0]                survive_mask,
  input  logic                      step_valid,
  output logic                      step_ready,
  output logic [WIDTH*HEIGHT-1:0]   states,
  output logic [GEN_W-1:0]          generation,
  output logic                      still,
  output logic                      extinct
`ifdef LIFE_HISTORY_EN
  ,
  output logic                      osc2
`endif
);

  localparam int CELLS = CELL_NUM(WIDTH, HEIGHT);
  localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(CELLS - 1);

  life_state_t      state;
  life_state_t      state_next;
  logic [IDX_W-1:0] idx;
  logic [CELLS-1:0] next_states;
  logic             step_fire;
  logic             load_fire;

`ifdef LIFE_HISTORY_EN
  logic [CELLS-1:0] prev;
`endif

  // Every cell evaluates in parallel; the whole grid commits on one edge.
  for (genvar r = 0; r < HEIGHT; r++) begin : g_row
    for (genvar c = 0; c < WIDTH; c++) begin : g_col
      logic [7:0] nbrs;
      for (genvar k = 0; k < 8; k++) begin : g_nbr
        localparam int NI = nbr_index(r, c, k, WIDTH, HEIGHT, TORUS);
        if (NI < 0) begin : g_dead
          assign nbrs[k] = 1'b0;
        end else begin : g_live
          assign nbrs[k] = states[NI];
        end
      end
      life_rule u_rule (
        .nbrs         (nbrs),
        .alive        (states[r*WIDTH+c]),
        .birth_mask   (birth_mask),
        .survive_mask (survive_mask),
        .next         (next_states[r*WIDTH+c])
      );
    end
  end

  // load_start takes priority over both a step and a load bit.
  assign step_fire = (state == IDLE) && step_valid && !load_start;
  assign load_fire = (state == LOAD) && load_valid && !load_start;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (load_start) state_next = LOAD;
      LOAD: if (load_fire && idx == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state == LOAD);
    step_ready = (state == IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx        <= '0;
      states     <= '0;
      generation <= '0;
      still      <= 1'b0;
      extinct    <= 1'b1;
`ifdef LIFE_HISTORY_EN
      prev       <= '0;
      osc2       <= 1'b0;
`endif
    end else if (load_start) begin
      idx    <= '0;
      states <= '0;
`ifdef LIFE_HISTORY_EN
      prev   <= '0;
      osc2   <= 1'b0;
`endif
    end else if (step_fire) begin
      states     <= next_states;
      generation <= generation + GEN_W'(1);
      still      <= (next_states == states);
      extinct    <= (next_states == '0);
`ifdef LIFE_HISTORY_EN
      prev       <= states;
      osc2       <= (next_states == prev) && (next_states != states);
`endif
    end else if (load_fire) begin
      states[idx] <= load_bit;
      idx         <= idx + IDX_W'(1);
      if (idx == LAST) begin
        generation <= '0;
        still      <= 1'b0;
        // Cells beyond idx are still cleared, so only earlier bits and this one matter.
        extinct    <= !(|states) && !load_bit;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/life_grid.md
Name: life_grid

Overview:
- Parametrised Life-like cellular automaton engine; successor to the fixed 17x17 B3/S23 grid.
- WIDTH x HEIGHT cell array with runtime birth/survive rule masks, selectable torus or dead-border topology, serial pattern loading and a step handshake.
- Also provides a generation counter and still/extinct status.
- Sits between the testbench or file loader and the ANSI display loop; the display reads the states vector between steps.

Parameters:
- WIDTH, 17, columns.
- HEIGHT, 17, rows.
- TORUS, 1, 1 = edges wrap; 0 = cells outside the grid read as dead.
- GEN_W, 32, width of the generation counter.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- load_start  in  1  pulse: begin a serial pattern load.
- load_valid  in  1  load_bit is valid this cycle.
- load_bit  in  1  next cell value, row-major, index 0 = row 0 col 0.
- load_ready  out  1  high while in LOAD.
- birth_mask  in  9  bit n set: a dead cell with n live neighbours is born.
- survive_mask  in  9  bit n set: a live cell with n live neighbours survives.
- step_valid  in  1  request one generation.
- step_ready  out  1  high in IDLE.
- states  out  WIDTH*HEIGHT  current generation, bit index row*WIDTH+col.
- generation  out  GEN_W  steps taken since the last completed load.
- still  out  1  the last step changed no cell.
- extinct  out  1  all cells are dead.

Behaviour:
- States: IDLE, LOAD.
- Reset values: IDLE, states=0, generation=0, still=0, extinct=1, load_ready=0, step_ready=1. Reset overrides everything, including in the middle of a load.
- IDLE -> LOAD: on load_start. Load index clears and states clear to 0.
- In LOAD, each cycle with load_valid=1:
  - states[idx] <= load_bit; idx increments.
  - On accepting idx = CELL_NUM-1, go to IDLE: generation <= 0, still <= 0, extinct <= (no live cell loaded).
- load_start while in LOAD restarts the load: idx=0, states cleared.
- step_valid is ignored in LOAD (step_ready=0).
- Step handshake: transfer when step_valid && step_ready.
  - The whole grid updates at that same edge; latency is 1 cycle.
  - New states are visible the cycle after the handshake.
  - Back-to-back steps are allowed: one generation per cycle while step_valid stays high.
- Next-state rule per cell:
  - n = sum of 8 neighbours, 4-bit, range 0..8.
  - next = state ? survive_mask[n] : birth_mask[n].
  - Masks are sampled at the handshake edge; bit 0 is meaningful (n=0).
- Neighbours:
  - TORUS=1: indices wrap modulo WIDTH/HEIGHT.
  - TORUS=0: any out-of-range neighbour contributes 0.
  - WIDTH or HEIGHT of 1 or 2 is legal; under TORUS=1 a cell may count the same neighbour more than once or count itself.
- Status updates on each step:
  - generation increments and wraps modulo 2^GEN_W.
  - still <= (next == states).
  - extinct <= (next == 0).
- load_start and step_valid in the same IDLE cycle: load_start wins, no step occurs.

Optional Feature:
- Macro LIFE_HISTORY_EN.
- Defined:
  - Adds a registered previous-generation copy and an output osc2 (1 bit).
  - On each step, osc2 <= (next == prev) && !(next == states), i.e. period-2 oscillator detected.
  - Load and reset clear prev and osc2.
  - The first step after a load compares against all-zero prev.
- Not defined: no osc2 port and no extra storage.

Decomposition:
- Package life_pkg holds:
  - CELL_NUM(W,H) function.
  - Rule constants RULE_B3 = 9'b000001000, RULE_S23 = 9'b000001100, RULE_B36 = 9'b001001000 (HighLife).
  - State enum {IDLE, LOAD}.
- Sub-module life_rule: combinational. Inputs: 8 neighbour bits, self, masks. Output: next.
- life_grid instantiates life_rule in a generate loop and owns all registers and the FSM.

Test Plan:
- Blinker, 5x5, TORUS=1, B3/S23. Load vertical at (1..3,2).
  - One step -> horizontal (2,1..3), generation=1, still=0.
  - Second step -> vertical again, generation=2.
  - With LIFE_HISTORY_EN: osc2=1 after step 2.
- 2x2 block at (0,0), 5x5, TORUS=0. One step -> states unchanged, still=1, extinct=0, generation=1.
- Same block at (4,4), 5x5:
  - TORUS=1: four corner cells form a block, stays still.
  - TORUS=0: each cell has 0 neighbours -> all die, extinct=1.
- Glider, 17x17, TORUS=1. 68 back-to-back steps with step_valid held high -> states equal the loaded pattern, generation=68.
- HighLife replicator seed vs B3/S23. Same load; after 1 step, cells with 6 neighbours differ according to birth_mask bit 6.
- Reset after 100 of 289 load bits -> IDLE, states=0, generation=0, extinct=1.
  - A full reload then behaves normally.
  - step_valid during LOAD -> no change, step_ready=0.
